// File: rtl/apb_master_gen.sv
// Parametrised APB4 requester: valid/ready command in, one-hot PSEL out,
// single-cycle response with slave error, decode error and wait timeout.
module apb_master_gen #(
   parameter  int NSLV    = 4,
   parameter  int DW      = 32,
   parameter  int AW      = 16,
   parameter  int TIMEOUT = 16,
   localparam int SELW    = (NSLV > 1) ? $clog2(NSLV) : 1
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [SELW-1:0]   cmd_sel,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW-1:0]     cmd_wdata,
   input  logic [DW/8-1:0]   cmd_strb,
   output logic [NSLV-1:0]   PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [AW-1:0]     PADDR,
   output logic [DW-1:0]     PWDATA,
   output logic [DW/8-1:0]   PSTRB,
   input  logic [NSLV-1:0]   PREADY,
   input  logic [NSLV*DW-1:0] PRDATA,
   input  logic [NSLV-1:0]   PSLVERR,
   output logic              rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DECERR
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_wait;
   logic [SELW-1:0] r_sel;

   logic          w_rdy;
   logic          w_err;
   logic [DW-1:0] w_rdata;
   logic          w_done;
   logic          w_to;
   logic          w_acc;
   logic          w_sel_ok;

   // Only the registered target drives the response path.
   always_comb begin
      w_rdy   = 1'b0;
      w_err   = 1'b0;
      w_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (r_sel == SELW'(i)) begin
            w_rdy   = PREADY[i];
            w_err   = PSLVERR[i];
            w_rdata = PRDATA[i*DW +: DW];
         end
      end
   end

   assign w_done = (r_state == S_ACCESS) && w_rdy;
   assign w_to   = (TIMEOUT != 0) && (r_state == S_ACCESS) && !w_rdy &&
                   (r_wait == CW'(TIMEOUT - 1));
   assign cmd_ready = (r_state == S_IDLE) || w_done || w_to;
   assign w_acc     = cmd_valid && cmd_ready;
   assign w_sel_ok  = ({1'b0, cmd_sel} < (SELW + 1)'(NSLV));
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_sel       <= '0;
         PSEL        <= '0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;

         if (w_done || w_to) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= w_to || w_err;
            rsp_timeout <= w_to;
            rsp_rdata   <= (w_done && !PWRITE && !w_err) ? w_rdata : '0;
         end
         if (r_state == S_DECERR) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
         end

         if (w_acc) begin
            PENABLE <= 1'b0;
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            r_sel   <= cmd_sel;
            if (w_sel_ok) begin
               r_state <= S_SETUP;
               PSEL    <= NSLV'(1) << cmd_sel;
               PWDATA  <= cmd_write ? cmd_wdata : '0;
               PSTRB   <= cmd_write ? cmd_strb : '0;
            end else begin
               r_state <= S_DECERR;
               PSEL    <= '0;
               PWDATA  <= '0;
               PSTRB   <= '0;
            end
         end else begin
            unique case (r_state)
               S_IDLE: ;
               S_SETUP: begin
                  r_state <= S_ACCESS;
                  PENABLE <= 1'b1;
                  r_wait  <= '0;
               end
               S_ACCESS: begin
                  if (w_done || w_to) begin
                     r_state <= S_IDLE;
                     PSEL    <= '0;
                     PENABLE <= 1'b0;
                     PWDATA  <= '0;
                     PSTRB   <= '0;
                  end else begin
                     r_wait <= r_wait + 1'b1;
                  end
               end
               S_DECERR: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_apb_master_gen.sv
// Directed bench for apb_master_gen with three completers and a
// four-cycle wait timeout.
module tb_apb_master_gen;

   logic        PCLK;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [1:0]  cmd_sel;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PREADY;
   logic [95:0] PRDATA;
   logic [2:0]  PSLVERR;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;

   int nvec = 0;
   int nerr = 0;

   apb_master_gen #(
      .NSLV(3), .DW(32), .AW(16), .TIMEOUT(4)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_sel(cmd_sel),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .cmd_strb(cmd_strb),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .busy(busy)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic w, input logic [1:0] s,
                      input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = s;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = b;
   endtask

   initial begin
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_sel   = '0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      PREADY    = '0;
      PRDATA    = '0;
      PSLVERR   = '0;
      tick();
      tick();
      chk("rst_psel", PSEL, 3'b000);
      chk("rst_pen", PENABLE, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp", rsp_valid, 1'b0);
      PRESET = 1'b0;

      // write, zero wait states
      cmd(1'b1, 2'd2, 16'h0040, 32'hDEADBEEF, 4'hF);
      PREADY = 3'b100;
      tick();
      cmd_valid = 1'b0;
      chk("wr_setup_psel", PSEL, 3'b100);
      chk("wr_setup_pen", PENABLE, 1'b0);
      chk("wr_setup_addr", PADDR, 16'h0040);
      chk("wr_setup_wdata", PWDATA, 32'hDEADBEEF);
      chk("wr_setup_strb", PSTRB, 4'hF);
      chk("wr_setup_pwrite", PWRITE, 1'b1);
      chk("wr_setup_ready", cmd_ready, 1'b0);
      tick();
      chk("wr_acc_pen", PENABLE, 1'b1);
      chk("wr_acc_psel", PSEL, 3'b100);
      chk("wr_acc_ready", cmd_ready, 1'b1);
      chk("wr_acc_rsp", rsp_valid, 1'b0);
      tick();
      chk("wr_rsp_valid", rsp_valid, 1'b1);
      chk("wr_rsp_err", rsp_err, 1'b0);
      chk("wr_rsp_rdata", rsp_rdata, 32'h0);
      chk("wr_idle_psel", PSEL, 3'b000);
      chk("wr_idle_busy", busy, 1'b0);
      tick();
      chk("wr_rsp_pulse", rsp_valid, 1'b0);

      // read, three wait states
      PREADY = 3'b000;
      PRDATA = {32'h99999999, 32'h12345678, 32'hAAAAAAAA};
      cmd(1'b0, 2'd1, 16'h1234, 32'hFFFFFFFF, 4'hF);
      tick();
      cmd_valid = 1'b0;
      chk("rd_setup_psel", PSEL, 3'b010);
      chk("rd_setup_wdata", PWDATA, 32'h0);
      chk("rd_setup_strb", PSTRB, 4'h0);
      tick();
      tick();
      tick();
      chk("rd_wait_pen", PENABLE, 1'b1);
      chk("rd_wait_strb", PSTRB, 4'h0);
      chk("rd_wait_ready", cmd_ready, 1'b0);
      chk("rd_wait_rsp", rsp_valid, 1'b0);
      tick();
      PREADY = 3'b010;
      tick();
      chk("rd_rsp_valid", rsp_valid, 1'b1);
      chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("rd_rsp_err", rsp_err, 1'b0);
      chk("rd_rsp_to", rsp_timeout, 1'b0);

      // back-to-back: second command waits through SETUP
      PREADY = 3'b001;
      cmd(1'b1, 2'd0, 16'h0010, 32'h11111111, 4'h3);
      tick();
      cmd(1'b0, 2'd2, 16'h0020, 32'h0, 4'h0);
      chk("b2b_setup_ready", cmd_ready, 1'b0);
      tick();
      chk("b2b_acc_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      PREADY = 3'b100;
      PRDATA[95:64] = 32'hCAFEF00D;
      chk("b2b_rsp1", rsp_valid, 1'b1);
      chk("b2b_setup2_psel", PSEL, 3'b100);
      chk("b2b_setup2_pen", PENABLE, 1'b0);
      chk("b2b_setup2_addr", PADDR, 16'h0020);
      chk("b2b_setup2_busy", busy, 1'b1);
      tick();
      chk("b2b_acc2_pen", PENABLE, 1'b1);
      tick();
      chk("b2b_rsp2_valid", rsp_valid, 1'b1);
      chk("b2b_rsp2_rdata", rsp_rdata, 32'hCAFEF00D);

      // slave error
      PREADY  = 3'b001;
      PSLVERR = 3'b001;
      PRDATA[31:0] = 32'h55555555;
      cmd(1'b0, 2'd0, 16'h0008, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("slv_rsp_valid", rsp_valid, 1'b1);
      chk("slv_rsp_err", rsp_err, 1'b1);
      chk("slv_rsp_rdata", rsp_rdata, 32'h0);
      chk("slv_rsp_to", rsp_timeout, 1'b0);
      PSLVERR = 3'b000;

      // decode error on select 3
      cmd(1'b1, 2'd3, 16'h0100, 32'h1, 4'hF);
      chk("dec_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("dec_psel", PSEL, 3'b000);
      chk("dec_pen", PENABLE, 1'b0);
      chk("dec_busy", busy, 1'b1);
      chk("dec_ready2", cmd_ready, 1'b0);
      chk("dec_norsp", rsp_valid, 1'b0);
      tick();
      chk("dec_rsp_valid", rsp_valid, 1'b1);
      chk("dec_rsp_err", rsp_err, 1'b1);
      chk("dec_rsp_to", rsp_timeout, 1'b0);
      chk("dec_idle", busy, 1'b0);

      // timeout with PREADY stuck low
      PREADY = 3'b000;
      PRDATA[63:32] = 32'h77777777;
      cmd(1'b0, 2'd1, 16'h0200, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("to_acc3_ready", cmd_ready, 1'b0);
      tick();
      chk("to_acc4_ready", cmd_ready, 1'b1);
      chk("to_acc4_pen", PENABLE, 1'b1);
      tick();
      chk("to_rsp_valid", rsp_valid, 1'b1);
      chk("to_rsp_err", rsp_err, 1'b1);
      chk("to_rsp_to", rsp_timeout, 1'b1);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_psel", PSEL, 3'b000);
      chk("to_pen", PENABLE, 1'b0);

      // timeout boundary: ready in the 4th ACCESS cycle
      cmd(1'b1, 2'd1, 16'h0300, 32'h01020304, 4'h5);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      PREADY = 3'b010;
      tick();
      chk("tb_rsp_valid", rsp_valid, 1'b1);
      chk("tb_rsp_err", rsp_err, 1'b0);
      chk("tb_rsp_to", rsp_timeout, 1'b0);

      // reset during ACCESS
      PREADY = 3'b000;
      cmd(1'b1, 2'd2, 16'h0400, 32'hA5A5A5A5, 4'hF);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mr_acc_pen", PENABLE, 1'b1);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      chk("mr_psel", PSEL, 3'b000);
      chk("mr_pen", PENABLE, 1'b0);
      chk("mr_paddr", PADDR, 16'h0);
      chk("mr_pwdata", PWDATA, 32'h0);
      chk("mr_pstrb", PSTRB, 4'h0);
      chk("mr_pwrite", PWRITE, 1'b0);
      chk("mr_rsp", rsp_valid, 1'b0);
      chk("mr_ready", cmd_ready, 1'b1);
      tick();
      chk("mr_rsp2", rsp_valid, 1'b0);
      chk("mr_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
